// File: rtl/frame_unpacker.sv
// frame_unpacker: receive side of a packed 32-bit status word.
//   in_word[31:25] enf, [24:15] mult (=6*load), [14:11] qtd, [10:5] base, [4:0] sync trailer.
// A word is taken on an in_valid/in_ready handshake. A word with a bad trailer is dropped and
// flagged with a one-cycle sync_err pulse. A good word is divided by 6 (10-cycle restoring
// divide), and the results are then offered on an out_valid/out_ready handshake.
// Ports:
//   sysclk, reset        clock (rising edge), synchronous active-low reset
//   in_word/in_valid/in_ready   input handshake
//   out_enf/out_load/out_rem/out_qtd/out_base/out_div_err   unpacked fields
//   out_valid/out_ready  output handshake
//   sync_err             pulse: frame dropped for bad trailer
//   frame_cnt, sync_err_cnt, div_err_cnt   saturating event counters
module frame_unpacker #(
  parameter logic [4:0]  SYNC_PAT = 5'b11001,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_enf,
  output logic [7:0]       out_load,
  output logic [2:0]       out_rem,
  output logic [3:0]       out_qtd,
  output logic [5:0]       out_base,
  output logic             out_div_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] div_err_cnt
);

  typedef enum logic [1:0] {StIdle, StDiv, StOut} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  state_e           state_q, state_d;
  logic [9:0]       dvd_q, dvd_d;
  logic [3:0]       prem_q, prem_d;
  // Quotient never exceeds 170, so the two bits shifted out of the top are always zero.
  logic [7:0]       quot_q, quot_d;
  logic [3:0]       iter_q, iter_d;
  // Fields of the frame in flight; out_* keep the previously delivered frame meanwhile.
  logic [6:0]       enf_q, enf_d;
  logic [3:0]       qtd_q, qtd_d;
  logic [5:0]       base_q, base_d;
  logic [6:0]       out_enf_q, out_enf_d;
  logic [7:0]       out_load_q, out_load_d;
  logic [2:0]       out_rem_q, out_rem_d;
  logic [3:0]       out_qtd_q, out_qtd_d;
  logic [5:0]       out_base_q, out_base_d;
  logic             out_div_err_q, out_div_err_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] sync_err_cnt_q, sync_err_cnt_d;
  logic [CNT_W-1:0] div_err_cnt_q, div_err_cnt_d;

  logic [3:0] shifted;
  logic       ge6;
  logic [3:0] prem_nxt;
  logic [7:0] quot_nxt;

  always_comb begin
    shifted  = {prem_q[2:0], dvd_q[9]};
    ge6      = (shifted >= 4'd6);
    prem_nxt = ge6 ? (shifted - 4'd6) : shifted;
    quot_nxt = {quot_q[6:0], ge6};

    state_d        = state_q;
    dvd_d          = dvd_q;
    prem_d         = prem_q;
    quot_d         = quot_q;
    iter_d         = iter_q;
    enf_d          = enf_q;
    qtd_d          = qtd_q;
    base_d         = base_q;
    out_enf_d      = out_enf_q;
    out_load_d     = out_load_q;
    out_rem_d      = out_rem_q;
    out_qtd_d      = out_qtd_q;
    out_base_d     = out_base_q;
    out_div_err_d  = out_div_err_q;
    sync_err_d     = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    sync_err_cnt_d = sync_err_cnt_q;
    div_err_cnt_d  = div_err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_word[4:0] != SYNC_PAT) begin
            sync_err_d     = 1'b1;
            sync_err_cnt_d = sat_inc(sync_err_cnt_q);
          end else begin
            enf_d   = in_word[31:25];
            dvd_d   = in_word[24:15];
            qtd_d   = in_word[14:11];
            base_d  = in_word[10:5];
            prem_d  = 4'd0;
            quot_d  = 8'd0;
            iter_d  = 4'd0;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        dvd_d  = {dvd_q[8:0], 1'b0};
        prem_d = prem_nxt;
        quot_d = quot_nxt;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          out_enf_d     = enf_q;
          out_load_d    = quot_nxt;
          out_rem_d     = prem_nxt[2:0];
          out_qtd_d     = qtd_q;
          out_base_d    = base_q;
          out_div_err_d = (prem_nxt != 4'd0);
          state_d       = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          frame_cnt_d = sat_inc(frame_cnt_q);
          if (out_div_err_q) div_err_cnt_d = sat_inc(div_err_cnt_q);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q        <= StIdle;
      dvd_q          <= '0;
      prem_q         <= '0;
      quot_q         <= '0;
      iter_q         <= '0;
      enf_q          <= '0;
      qtd_q          <= '0;
      base_q         <= '0;
      out_enf_q      <= '0;
      out_load_q     <= '0;
      out_rem_q      <= '0;
      out_qtd_q      <= '0;
      out_base_q     <= '0;
      out_div_err_q  <= 1'b0;
      sync_err_q     <= 1'b0;
      frame_cnt_q    <= '0;
      sync_err_cnt_q <= '0;
      div_err_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      dvd_q          <= dvd_d;
      prem_q         <= prem_d;
      quot_q         <= quot_d;
      iter_q         <= iter_d;
      enf_q          <= enf_d;
      qtd_q          <= qtd_d;
      base_q         <= base_d;
      out_enf_q      <= out_enf_d;
      out_load_q     <= out_load_d;
      out_rem_q      <= out_rem_d;
      out_qtd_q      <= out_qtd_d;
      out_base_q     <= out_base_d;
      out_div_err_q  <= out_div_err_d;
      sync_err_q     <= sync_err_d;
      frame_cnt_q    <= frame_cnt_d;
      sync_err_cnt_q <= sync_err_cnt_d;
      div_err_cnt_q  <= div_err_cnt_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StOut);
  assign out_enf      = out_enf_q;
  assign out_load     = out_load_q;
  assign out_rem      = out_rem_q;
  assign out_qtd      = out_qtd_q;
  assign out_base     = out_base_q;
  assign out_div_err  = out_div_err_q;
  assign sync_err     = sync_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign sync_err_cnt = sync_err_cnt_q;
  assign div_err_cnt  = div_err_cnt_q;

endmodule

// File: tb/tb_frame_unpacker.sv
// Directed bench for frame_unpacker: a default build plus a CNT_W=4 build sharing the same
// stimulus, the narrow one used to reach counter saturation quickly.
module tb_frame_unpacker;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [31:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_div_err, out_valid, sync_err;
  logic [6:0]  out_enf;
  logic [7:0]  out_load;
  logic [2:0]  out_rem;
  logic [3:0]  out_qtd;
  logic [5:0]  out_base;
  logic [15:0] frame_cnt, sync_err_cnt, div_err_cnt;

  logic        in_ready4, out_div_err4, out_valid4, sync_err4;
  logic [6:0]  out_enf4;
  logic [7:0]  out_load4;
  logic [2:0]  out_rem4;
  logic [3:0]  out_qtd4;
  logic [5:0]  out_base4;
  logic [3:0]  frame_cnt4, sync_err_cnt4, div_err_cnt4;

  int checks   = 0;
  int failures = 0;

  frame_unpacker dut (
    .sysclk(sysclk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_enf(out_enf), .out_load(out_load), .out_rem(out_rem),
    .out_qtd(out_qtd), .out_base(out_base), .out_div_err(out_div_err),
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err),
    .frame_cnt(frame_cnt), .sync_err_cnt(sync_err_cnt), .div_err_cnt(div_err_cnt)
  );

  frame_unpacker #(.CNT_W(4)) dut4 (
    .sysclk(sysclk), .reset(reset), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready4), .out_enf(out_enf4), .out_load(out_load4), .out_rem(out_rem4),
    .out_qtd(out_qtd4), .out_base(out_base4), .out_div_err(out_div_err4),
    .out_valid(out_valid4), .out_ready(out_ready), .sync_err(sync_err4),
    .frame_cnt(frame_cnt4), .sync_err_cnt(sync_err_cnt4), .div_err_cnt(div_err_cnt4)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_word  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns edges until out_valid, bounded.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) chk({tag, "_in_ready_div"}, 32'(in_ready), 0);
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 10);
  endtask

  initial begin
    bit saw_valid;
    reset     = 1'b0;
    in_word   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b1;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_out_load", out_load, 0);

    // Frame 1: 222/6 = 37 r0
    send(32'hAA6F5599);
    chk("f1_in_ready", in_ready, 0);
    wait_out("f1");
    chk("f1_enf", out_enf, 7'h55);
    chk("f1_load", out_load, 37);
    chk("f1_rem", out_rem, 0);
    chk("f1_qtd", out_qtd, 4'hA);
    chk("f1_base", out_base, 6'h2C);
    chk("f1_div_err", out_div_err, 0);
    step();
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_valid_drop", out_valid, 0);
    chk("f1_in_ready_back", in_ready, 1);

    // Bad trailer dropped, good word accepted on the very next edge
    send(32'hAA6F5598);
    chk("bad_sync_err", sync_err, 1);
    chk("bad_sync_cnt", sync_err_cnt, 1);
    chk("bad_out_valid", out_valid, 0);
    chk("bad_in_ready", in_ready, 1);
    send(32'hAA6F5599);
    chk("b2b_sync_err_pulse", sync_err, 0);
    chk("b2b_accepted", in_ready, 0);
    chk("b2b_fields_hold", out_load, 37);
    wait_out("b2b");
    chk("b2b_load", out_load, 37);
    step();
    chk("b2b_frame_cnt", frame_cnt, 2);
    chk("b2b_sync_cnt", sync_err_cnt, 1);

    // mult=223: 37 r1
    send(32'hAA6FD599);
    wait_out("f3");
    chk("f3_load", out_load, 37);
    chk("f3_rem", out_rem, 1);
    chk("f3_div_err", out_div_err, 1);
    chk("f3_div_cnt_pre", div_err_cnt, 0);
    step();
    chk("f3_div_cnt", div_err_cnt, 1);
    chk("f3_frame_cnt", frame_cnt, 3);

    // mult=1023: 170 r3, downstream stalls 5 cycles
    out_ready = 1'b0;
    send(32'h01FF8019);
    chk("f4_rem_hold_div", out_rem, 1);
    wait_out("f4");
    for (int i = 0; i < 5; i++) begin
      chk("f4_stall_load", out_load, 170);
      chk("f4_stall_rem", out_rem, 3);
      chk("f4_stall_valid", out_valid, 1);
      chk("f4_stall_in_ready", in_ready, 0);
      chk("f4_stall_frame_cnt", frame_cnt, 3);
      step();
    end
    chk("f4_enf", out_enf, 0);
    chk("f4_div_err", out_div_err, 1);
    out_ready = 1'b1;
    step();
    chk("f4_frame_cnt", frame_cnt, 4);
    chk("f4_div_cnt", div_err_cnt, 2);
    step();
    chk("f4_idle_ready_noop", frame_cnt, 4);
    chk("f4_idle_load_hold", out_load, 170);

    // Reset midway through DIV aborts the frame
    send(32'hAA6F5599);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_frame_cnt", frame_cnt, 0);
    chk("mid_sync_cnt", sync_err_cnt, 0);
    chk("mid_div_cnt", div_err_cnt, 0);
    chk("mid_load", out_load, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) saw_valid = 1'b1;
      step();
    end
    chk("mid_no_output", saw_valid, 0);

    // mult=0, then 15 more good frames: 4-bit counter saturates at 15
    send(32'h00000019);
    wait_out("zero");
    chk("zero_load", out_load, 0);
    chk("zero_rem", out_rem, 0);
    chk("zero_div_err", out_div_err, 0);
    step();
    for (int i = 0; i < 15; i++) begin
      send(32'hAA6F5599);
      for (int k = 0; k < 40 && !out_valid; k++) step();
      step();
    end
    chk("sat_frame_cnt16", frame_cnt, 16);
    chk("sat_frame_cnt4", frame_cnt4, 4'hF);
    chk("sat_div_cnt4", div_err_cnt4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
